chip_addr_bank: RTL and testbench
=================================

CHIP_ADDR_BANK -- requirements
Module: chip_addr_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent chip-address channels (1..16).
REQ-002 SHALL have parameter ADDR_W, default 4: width of each output chip address (1..8).
REQ-003 SHALL have parameter IN_W, default 8: width of the CHIP_ADDR_IN bus (IN_W >= ADDR_W).
REQ-004 SHALL have parameter RESET_ADDR, default 0: per-channel address loaded at reset.
REQ-005 SHALL have parameter HOLD_TIMEOUT, default 1024: maximum cycles a pending write waits for HOLD to drop (>= 1).
REQ-006 SHALL have port CLK, input, 1, the single clock for all logic.
REQ-007 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port SET, input, 1, write request; the rising edge is significant.
REQ-009 SHALL have port CH_SEL, input, max(1,clog2(NUM_CH)): target channel.
REQ-010 SHALL have port BCAST, input, 1: when high, the write targets all channels and CH_SEL is ignored.
REQ-011 SHALL have port CHIP_ADDR_IN, input, IN_W: new address.
REQ-012 SHALL have port HOLD, input, 1: downstream busy; output updates are deferred while it is high.
REQ-013 SHALL have port CHIP_ADDR_OUT, output, NUM_CH*ADDR_W: channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-014 SHALL have port ADDR_VALID, output, NUM_CH: channel written at least once since reset.
REQ-015 SHALL have port BUSY, output, 1: FSM not in IDLE.
REQ-016 SHALL have port UPDATED, output, 1: one-cycle pulse when a write is applied.
REQ-017 SHALL have port ERR, output, 1: one-cycle pulse when a write is rejected.
REQ-018 SHALL have port ERR_CODE, output, 2: cause of the last rejection.

Function
REQ-019 SHALL register SET, CH_SEL, BCAST and CHIP_ADDR_IN through two flop stages (q1, q2), then register SET once more (q3) for edge detection; a rising edge is q2 & ~q3.
REQ-020 SHALL implement the FSM states IDLE, CHECK, WAIT, APPLY and REJECT, encoded as a registered state.
REQ-021 SHALL, from IDLE on a detected edge, latch CH_SEL/BCAST/CHIP_ADDR_IN from stage q2 and go to CHECK.
REQ-022 SHALL, in CHECK, select the error code: 01 if not BCAST and CH_SEL >= NUM_CH; 10 if CHIP_ADDR_IN[IN_W-1:ADDR_W] is nonzero; code 01 takes priority over 10.
REQ-023 SHALL leave CHECK as follows: error -> REJECT; else HOLD high -> WAIT with the timeout counter cleared; else -> APPLY.
REQ-024 SHALL, in WAIT, increment the counter each cycle; HOLD low -> APPLY; counter reaching HOLD_TIMEOUT-1 with HOLD still high -> REJECT with code 11.
REQ-025 SHALL, in APPLY, write CHIP_ADDR_IN[ADDR_W-1:0] to the target channel (all channels if BCAST), set the matching ADDR_VALID bits, pulse UPDATED for one cycle, and return to IDLE.
REQ-026 SHALL, in REJECT, pulse ERR for one cycle, load ERR_CODE, leave CHIP_ADDR_OUT unchanged, and return to IDLE.
REQ-027 SHALL hold ERR_CODE until the next rejection or reset.
REQ-028 SHALL drive BUSY combinationally as (state != IDLE).
REQ-029 SHALL ignore SET edges detected while not in IDLE; no queueing.
REQ-030 SHALL, with HOLD low, have CHIP_ADDR_OUT and UPDATED change after clock edge k+4, where k is the first edge that samples SET high; ERR behaves the same for code 01/10.
REQ-031 SHALL treat SET held high continuously as a single write.
REQ-032 SHALL register every output.

Reset
REQ-033 SHALL, with RST high at a clock edge, set: state IDLE, all pipeline flops 0, every CHIP_ADDR_OUT channel RESET_ADDR[ADDR_W-1:0], ADDR_VALID 0, UPDATED 0, ERR 0, ERR_CODE 00, counter 0.
REQ-034 SHALL, on reset during CHECK, WAIT or APPLY, discard the pending write with no UPDATED or ERR pulse.
REQ-035 SHALL NOT detect a SET already high when RST releases as an edge until SET has been seen low.

Structure
REQ-036 SHALL place the FSM state type and the ERR_CODE constants (NONE=00, BAD_CH=01, OVERFLOW=10, TIMEOUT=11) in the shared package chip_addr_pkg.
REQ-037 SHALL implement the two-stage input registration plus edge detect as the sub-module cfg_in_pipe, parameterised by payload width.

Verification
REQ-038 SHALL verify: NUM_CH=4, HOLD=0, SET edge with CH_SEL=2, CHIP_ADDR_IN=0x0A -> channel 2 = 0xA at edge k+4, ADDR_VALID=0100, UPDATED pulses once, other channels stay RESET_ADDR.
REQ-039 SHALL verify: BCAST=1, CHIP_ADDR_IN=0x05 -> all four channels = 0x5, ADDR_VALID=1111, one UPDATED pulse.
REQ-040 SHALL verify: CHIP_ADDR_IN=0x1F -> ERR pulse with ERR_CODE=10 and outputs unchanged; NUM_CH=3 with CH_SEL=3 -> ERR_CODE=01.
REQ-041 SHALL verify: HOLD_TIMEOUT=16, HOLD high for 10 cycles after the edge -> apply happens the cycle after HOLD falls; HOLD held high for 20 cycles -> ERR with ERR_CODE=11, BUSY high for exactly 18 cycles.
REQ-042 SHALL verify: a second SET edge while BUSY is ignored, and RST asserted in WAIT returns all outputs to reset values with no pulses.

Source files
------------

// File: rtl/chip_addr_pkg.sv
// rtl/chip_addr_pkg.sv - shared FSM state type and error codes for chip_addr_bank
package chip_addr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_APPLY  = 3'd3,
    ST_REJECT = 3'd4
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE     = 2'b00;
  localparam err_code_t ERR_BAD_CH   = 2'b01;
  localparam err_code_t ERR_OVERFLOW = 2'b10;
  localparam err_code_t ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/cfg_in_pipe.sv
// rtl/cfg_in_pipe.sv - two-stage input registration with rising-edge detect on set
module cfg_in_pipe #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         set,
  input  logic [W-1:0] data,
  output logic         edge_det,
  output logic [W-1:0] data_q2
);

  logic         set_q1, set_q2, set_q3;
  logic [W-1:0] data_q1;
  logic [1:0]   fill;
  logic         armed;

  // armed only after q2 holds a post-reset low sample, so a level held across reset is not an edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      set_q1  <= 1'b0;
      set_q2  <= 1'b0;
      set_q3  <= 1'b0;
      data_q1 <= '0;
      data_q2 <= '0;
      fill    <= '0;
      armed   <= 1'b0;
    end else begin
      set_q1  <= set;
      set_q2  <= set_q1;
      set_q3  <= set_q2;
      data_q1 <= data;
      data_q2 <= data_q1;
      fill    <= {fill[0], 1'b1};
      if (fill[1] && !set_q2) armed <= 1'b1;
    end
  end

  assign edge_det = set_q2 & ~set_q3 & armed;

endmodule

// File: rtl/chip_addr_bank.sv
// rtl/chip_addr_bank.sv - bank of chip-address registers written through a checked, hold-aware FSM
module chip_addr_bank
  import chip_addr_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          ADDR_W       = 4,
  parameter int          IN_W         = 8,
  parameter int unsigned RESET_ADDR   = 0,
  parameter int          HOLD_TIMEOUT = 1024,
  localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     SET,
  input  logic [CH_W-1:0]          CH_SEL,
  input  logic                     BCAST,
  input  logic [IN_W-1:0]          CHIP_ADDR_IN,
  input  logic                     HOLD,
  output logic [NUM_CH*ADDR_W-1:0] CHIP_ADDR_OUT,
  output logic [NUM_CH-1:0]        ADDR_VALID,
  output logic                     BUSY,
  output logic                     UPDATED,
  output logic                     ERR,
  output logic [1:0]               ERR_CODE
);

  localparam int              PW       = 1 + CH_W + IN_W;
  localparam int              CNT_W    = $clog2(HOLD_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic            edge_det;
  logic [PW-1:0]   pipe_q2;
  logic            bcast_l;
  logic [CH_W-1:0] ch_l;
  logic [IN_W-1:0] din_l;
  logic [CNT_W-1:0] cnt;
  err_code_t       chk_code, rej_code;
  logic            timeout;

  cfg_in_pipe #(.W(PW)) u_in_pipe (
    .CLK      (CLK),
    .RST      (RST),
    .set      (SET),
    .data     ({BCAST, CH_SEL, CHIP_ADDR_IN}),
    .edge_det (edge_det),
    .data_q2  (pipe_q2)
  );

  // bad channel outranks overflow
  always_comb begin
    chk_code = ERR_NONE;
    if (!bcast_l && (int'(ch_l) >= NUM_CH)) chk_code = ERR_BAD_CH;
    else if ((din_l >> ADDR_W) != '0)        chk_code = ERR_OVERFLOW;
  end

  assign timeout = (cnt == CNT_LAST);
  assign BUSY    = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (edge_det) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (chk_code != ERR_NONE) state_nxt = ST_REJECT;
        else if (HOLD)            state_nxt = ST_WAIT;
        else                      state_nxt = ST_APPLY;
      end
      ST_WAIT: begin
        if (!HOLD)        state_nxt = ST_APPLY;
        else if (timeout) state_nxt = ST_REJECT;
      end
      ST_APPLY:  state_nxt = ST_IDLE;
      ST_REJECT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      bcast_l       <= 1'b0;
      ch_l          <= '0;
      din_l         <= '0;
      cnt           <= '0;
      rej_code      <= ERR_NONE;
      CHIP_ADDR_OUT <= {NUM_CH{ADDR_W'(RESET_ADDR)}};
      ADDR_VALID    <= '0;
      UPDATED       <= 1'b0;
      ERR           <= 1'b0;
      ERR_CODE      <= ERR_NONE;
    end else begin
      state   <= state_nxt;
      UPDATED <= 1'b0;
      ERR     <= 1'b0;
      if (state == ST_IDLE && edge_det) {bcast_l, ch_l, din_l} <= pipe_q2;
      if (state == ST_CHECK) begin
        cnt      <= '0;
        rej_code <= chk_code;
      end
      if (state == ST_WAIT) begin
        cnt <= cnt + 1'b1;
        if (HOLD && timeout) rej_code <= ERR_TIMEOUT;
      end
      if (state == ST_APPLY) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (bcast_l || (int'(ch_l) == i)) begin
            CHIP_ADDR_OUT[i*ADDR_W +: ADDR_W] <= din_l[ADDR_W-1:0];
            ADDR_VALID[i]                     <= 1'b1;
          end
        end
        UPDATED <= 1'b1;
      end
      if (state == ST_REJECT) begin
        ERR      <= 1'b1;
        ERR_CODE <= rej_code;
      end
    end
  end

endmodule

// File: tb/tb_chip_addr_bank.sv
// tb/tb_chip_addr_bank.sv - randomized self-checking bench for chip_addr_bank
module tb_chip_addr_bank;

  localparam int TMO = 16;

  logic        CLK = 1'b0;
  logic        RST, SET, SET3, BCAST, HOLD;
  logic [1:0]  CH_SEL;
  logic [7:0]  CHIP_ADDR_IN;
  logic [15:0] CHIP_ADDR_OUT;
  logic [3:0]  ADDR_VALID;
  logic        BUSY, UPDATED, ERR;
  logic [1:0]  ERR_CODE;
  logic [11:0] out3;
  logic [2:0]  valid3;
  logic        busy3, upd3, err3;
  logic [1:0]  code3;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_addr [4];
  logic [3:0] exp_valid;
  logic [1:0] exp_code;
  logic [3:0] exp3_addr [3];
  logic [2:0] exp3_valid;
  logic [1:0] exp3_code;

  always #5 CLK = ~CLK;

  chip_addr_bank #(.NUM_CH(4), .ADDR_W(4), .IN_W(8), .RESET_ADDR(3), .HOLD_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .SET(SET), .CH_SEL(CH_SEL), .BCAST(BCAST),
    .CHIP_ADDR_IN(CHIP_ADDR_IN), .HOLD(HOLD), .CHIP_ADDR_OUT(CHIP_ADDR_OUT),
    .ADDR_VALID(ADDR_VALID), .BUSY(BUSY), .UPDATED(UPDATED), .ERR(ERR), .ERR_CODE(ERR_CODE)
  );

  chip_addr_bank #(.NUM_CH(3), .ADDR_W(4), .IN_W(8), .RESET_ADDR(3), .HOLD_TIMEOUT(TMO)) dut3 (
    .CLK(CLK), .RST(RST), .SET(SET3), .CH_SEL(CH_SEL), .BCAST(BCAST),
    .CHIP_ADDR_IN(CHIP_ADDR_IN), .HOLD(HOLD), .CHIP_ADDR_OUT(out3),
    .ADDR_VALID(valid3), .BUSY(busy3), .UPDATED(upd3), .ERR(err3), .ERR_CODE(code3)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // 0 = accepted, 1 = bad channel, 2 = overflow
  function automatic int classify(int n, int ch, int bc, int data);
    if (bc == 0 && ch >= n) return 1;
    if (data > 15) return 2;
    return 0;
  endfunction

  function automatic logic [15:0] exp_bus();
    logic [15:0] b;
    for (int i = 0; i < 4; i++) b[i*4 +: 4] = exp_addr[i];
    return b;
  endfunction

  function automatic logic [11:0] exp3_bus();
    logic [11:0] b;
    for (int i = 0; i < 3; i++) b[i*4 +: 4] = exp3_addr[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_addr[i] = 4'h3;
    for (int i = 0; i < 3; i++) exp3_addr[i] = 4'h3;
    exp_valid  = '0;
    exp_code   = 2'b00;
    exp3_valid = '0;
    exp3_code  = 2'b00;
  endtask

  // extra: 0 plain, 1 second SET edge while busy, 2 reset asserted while waiting on HOLD
  task automatic run_write(input int ch, input int bc, input int data, input int hold_len, input int extra);
    int code, lat, busy_exp, set_len;
    int busy_n, upd_n, err_n, upd_at, err_at;
    code = classify(4, ch, bc, data);
    if (code == 0 && hold_len > TMO + 3) code = 3;
    if (code != 0)         begin lat = (code == 3) ? TMO + 4 : 4; busy_exp = (code == 3) ? TMO + 2 : 2; end
    else if (hold_len <= 3) begin lat = 4; busy_exp = 2; end
    else                    begin lat = hold_len + 1; busy_exp = hold_len - 1; end
    if (extra == 2) busy_exp = 5;
    set_len = (extra == 1) ? $urandom_range(1, 3) : $urandom_range(1, 8);
    busy_n = 0; upd_n = 0; err_n = 0; upd_at = -1; err_at = -1;
    CH_SEL = 2'(ch); BCAST = bc[0]; CHIP_ADDR_IN = 8'(data);
    HOLD = (hold_len > 0); SET = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      if (BUSY) busy_n++;
      if (UPDATED) begin upd_n++; if (upd_at < 0) upd_at = i; end
      if (ERR) begin err_n++; if (err_at < 0) err_at = i; end
      if (i == lat - 1 && extra != 2) begin
        checks++;
        if (CHIP_ADDR_OUT !== exp_bus()) begin
          errors++; $display("FAIL pre_update: got %h expected %h", CHIP_ADDR_OUT, exp_bus());
        end
      end
      if (i + 1 == set_len) SET = 1'b0;
      if (extra == 1 && i == 5) SET = 1'b1;
      if (extra == 1 && i == 7) SET = 1'b0;
      if (i + 1 == hold_len) HOLD = 1'b0;
      if (extra == 2 && i == 6) RST = 1'b1;
      if (extra == 2 && i == 7) RST = 1'b0;
    end
    if (extra == 2) model_reset();
    else if (code == 0) begin
      for (int i = 0; i < 4; i++)
        if (bc != 0 || ch == i) begin exp_addr[i] = 4'(data); exp_valid[i] = 1'b1; end
    end else exp_code = 2'(code);

    checks++;
    if (upd_n !== ((code == 0 && extra != 2) ? 1 : 0)) begin
      errors++; $display("FAIL updated_count: got %0d ch=%0d bc=%0d d=%h hold=%0d", upd_n, ch, bc, data, hold_len);
    end
    checks++;
    if (err_n !== ((code != 0 && extra != 2) ? 1 : 0)) begin
      errors++; $display("FAIL err_count: got %0d ch=%0d bc=%0d d=%h hold=%0d", err_n, ch, bc, data, hold_len);
    end
    if (extra != 2) begin
      checks++;
      if (((code == 0) ? upd_at : err_at) !== lat) begin
        errors++; $display("FAIL pulse_latency: got upd@%0d err@%0d expected %0d", upd_at, err_at, lat);
      end
    end
    checks++;
    if (busy_n !== busy_exp) begin
      errors++; $display("FAIL busy_cycles: got %0d expected %0d", busy_n, busy_exp);
    end
    checks++;
    if (CHIP_ADDR_OUT !== exp_bus()) begin
      errors++; $display("FAIL chip_addr_out: got %h expected %h", CHIP_ADDR_OUT, exp_bus());
    end
    checks++;
    if (ADDR_VALID !== exp_valid) begin
      errors++; $display("FAIL addr_valid: got %b expected %b", ADDR_VALID, exp_valid);
    end
    checks++;
    if (ERR_CODE !== exp_code) begin
      errors++; $display("FAIL err_code: got %b expected %b", ERR_CODE, exp_code);
    end
  endtask

  task automatic run_write3(input int ch, input int bc, input int data);
    int code, e_n, u_n, at;
    code = classify(3, ch, bc, data);
    e_n = 0; u_n = 0; at = -1;
    CH_SEL = 2'(ch); BCAST = bc[0]; CHIP_ADDR_IN = 8'(data); HOLD = 1'b0; SET3 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (err3) begin e_n++; if (at < 0) at = i; end
      if (upd3) begin u_n++; if (at < 0) at = i; end
      if (i == 1) SET3 = 1'b0;
    end
    if (code == 0) begin
      for (int i = 0; i < 3; i++)
        if (bc != 0 || ch == i) begin exp3_addr[i] = 4'(data); exp3_valid[i] = 1'b1; end
    end else exp3_code = 2'(code);
    checks++;
    if (e_n !== ((code != 0) ? 1 : 0) || u_n !== ((code == 0) ? 1 : 0) || at !== 4) begin
      errors++; $display("FAIL ch3_pulses: err=%0d upd=%0d at=%0d for ch=%0d bc=%0d", e_n, u_n, at, ch, bc);
    end
    checks++;
    if (out3 !== exp3_bus() || valid3 !== exp3_valid || code3 !== exp3_code) begin
      errors++; $display("FAIL ch3_state: got %h/%b/%b expected %h/%b/%b",
                         out3, valid3, code3, exp3_bus(), exp3_valid, exp3_code);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; SET = 1'b0; SET3 = 1'b0; BCAST = 1'b0; HOLD = 1'b0;
    CH_SEL = '0; CHIP_ADDR_IN = '0;
    step(); step();
    RST = 1'b0;
    model_reset();
    checks++;
    if (CHIP_ADDR_OUT !== 16'h3333 || out3 !== 12'h333) begin
      errors++; $display("FAIL reset_addr: got %h / %h", CHIP_ADDR_OUT, out3);
    end
    checks++;
    if ({ADDR_VALID, BUSY, UPDATED, ERR, ERR_CODE} !== 9'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0", {ADDR_VALID, BUSY, UPDATED, ERR, ERR_CODE});
    end
    repeat (4) step();
  endtask

  task automatic test_single_write();  run_write(2, 0, 'h0A, 0, 0); endtask
  task automatic test_broadcast();     run_write(1, 1, 'h05, 0, 0); endtask
  task automatic test_overflow();      run_write(0, 0, 'h1F, 0, 0); endtask

  task automatic test_bad_channel();
    run_write3(3, 0, 'h07);
    run_write3(3, 1, 'h09);
    run_write3(2, 0, 'h30);
  endtask

  task automatic test_hold();
    run_write(3, 0, 'h0C, 10, 0);
    run_write(0, 0, 'h0D, 3, 0);
    run_write(0, 0, 'h0E, 4, 0);
    run_write(1, 0, 'h09, TMO + 3, 0);
    run_write(2, 0, 'h06, 20, 0);
  endtask

  task automatic test_back_to_back();  run_write(1, 0, 'h07, 12, 1); endtask
  task automatic test_reset_in_wait(); run_write(2, 0, 'h0B, 12, 2); endtask

  task automatic test_set_at_reset();
    int busy_n;
    busy_n = 0;
    RST = 1'b1; SET = 1'b1; CH_SEL = 2'd1; BCAST = 1'b0; CHIP_ADDR_IN = 8'h04;
    step(); step();
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      if (BUSY || UPDATED) busy_n++;
    end
    checks++;
    if (busy_n !== 0 || ADDR_VALID !== 4'b0) begin
      errors++; $display("FAIL set_held_over_reset: busy/upd cycles %0d valid %b expected 0", busy_n, ADDR_VALID);
    end
    SET = 1'b0;
    repeat (4) step();
    run_write(1, 0, 'h04, 0, 0);
  endtask

  task automatic test_random();
    int ch, bc, data, hold;
    for (int n = 0; n < 25; n++) begin
      ch   = $urandom_range(0, 3);
      bc   = ($urandom_range(0, 3) == 0) ? 1 : 0;
      data = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      hold = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 25);
      run_write(ch, bc, data, hold, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_broadcast();
    test_overflow();
    test_bad_channel();
    test_hold();
    test_back_to_back();
    test_reset_in_wait();
    test_set_at_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
